// File: rtl/mem_access_stall.sv
// mem_access_stall: Y86 M-stage data memory with a fixed multi-cycle read latency.
// Reads (mrmovq/popq/ret) stall the pipeline until their data is about to land.
// Writes (rmmovq/pushq/call) and no-op icodes complete in one cycle.
// Optional feature: define MEM_ALIGN_CHECK_EN to report misaligned memory addresses as ADR.
module mem_access_stall #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              M_valid_i,
  input  logic [3:0]        M_icode_i,
  input  logic [63:0]       M_valE_i,
  input  logic [DATA_W-1:0] M_valA_i,
  input  logic [2:0]        M_stat_i,
  output logic [DATA_W-1:0] m_valM_o,
  output logic [2:0]        m_stat_o,
  output logic              m_valid_o,
  output logic              m_stall_o
);

  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int OFF_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 0;
  localparam int IDX_W          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Byte-level bounds, kept one bit wider than an address so addr+word never wraps
  localparam logic [64:0] BYTE_LIMIT = 65'(DEPTH_WORDS) * 65'(BYTES_PER_WORD);
  localparam logic [64:0] WORD_BYTES = 65'(BYTES_PER_WORD);

  // BUSY lasts RD_LAT-1 cycles; the counter counts those cycles down to 1
  localparam logic [1:0] CNT_LOAD    = 2'(RD_LAT - 1);
  localparam bit         MULTI_CYCLE = (RD_LAT > 1);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'h1;
  localparam logic [2:0] STAT_ADR = 3'h3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  logic              is_read;
  logic              is_write;
  logic              use_vala;
  logic              is_mem;
  logic [63:0]       vala_addr;
  logic [63:0]       mem_addr;
  logic [64:0]       addr_end;
  logic              out_of_range;
  logic              misaligned;
  logic              addr_err;
  logic              stat_ok;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic              do_read;
  logic              do_write;
  logic              slow_read;
  logic              last_busy;
  logic [2:0]        res_stat;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Classify the icode as read, write or no-op and pick its address source
  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    use_vala = 1'b0;
    case (M_icode_i)
      I_MRMOVQ: is_read = 1'b1;
      I_POPQ, I_RET: begin
        is_read  = 1'b1;
        use_vala = 1'b1;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: is_write = 1'b1;
      default: ;
    endcase
  end

  assign is_mem    = is_read | is_write;
  assign vala_addr = 64'(M_valA_i);
  assign mem_addr  = use_vala ? vala_addr : M_valE_i;

  // The whole word must fit below the byte limit
  assign addr_end     = {1'b0, mem_addr} + WORD_BYTES;
  assign out_of_range = addr_end > BYTE_LIMIT;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [63:0] OFF_MASK = 64'(BYTES_PER_WORD - 1);
  assign misaligned = (mem_addr & OFF_MASK) != 64'd0;
`else
  assign misaligned = 1'b0;
`endif

  assign addr_err = is_mem && (out_of_range || misaligned);
  assign stat_ok  = (M_stat_i == STAT_AOK);
  assign word_idx = IDX_W'(mem_addr >> OFF_W);
  assign rd_word  = mem_q[word_idx];

  // Only an idle FSM looks at the M-stage inputs; reset blocks acceptance outright
  assign accept    = !rst_i && (state_q == IDLE) && M_valid_i;
  assign do_read   = accept && stat_ok && is_read && !addr_err;
  assign do_write  = accept && stat_ok && is_write && !addr_err;
  assign slow_read = do_read && MULTI_CYCLE;
  assign last_busy = (state_q == BUSY) && (cnt_q <= 2'd1);

  // Status reported for single-cycle results: ADR only when the input was clean
  assign res_stat = (stat_ok && addr_err) ? STAT_ADR : M_stat_i;

  // Stall holds the M register from acceptance until one cycle before data lands
  assign m_stall_o = slow_read || ((state_q == BUSY) && (cnt_q > 2'd1));

  // Data array and multi-cycle read capture; deliberately not reset so contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[word_idx] <= M_valA_i;
    end
    if (do_read) begin
      rd_data_q <= rd_word;
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a slow read enters BUSY, which ends after its final counted cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (slow_read) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (last_busy) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Result registers: one-cycle results on acceptance, slow reads when BUSY finishes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_valM_o  <= '0;
      m_stat_o  <= STAT_AOK;
    end else if (accept && !slow_read) begin
      m_valid_o <= 1'b1;
      m_stat_o  <= res_stat;
      m_valM_o  <= do_read ? rd_word : '0;
    end else if (last_busy) begin
      m_valid_o <= 1'b1;
      m_stat_o  <= STAT_AOK;
      m_valM_o  <= rd_data_q;
    end else begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/mem_access_stall.md
MEM_ACCESS_STALL -- requirements
Module: mem_access_stall

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, data word width in bits (multiple of 8).
REQ-002 SHALL provide parameter DEPTH_WORDS, default 1024, number of DATA_W words in the data array; byte limit = DEPTH_WORDS*DATA_W/8.
REQ-003 SHALL provide parameter RD_LAT, default 2, read latency in cycles, legal 1..4.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset; there are no other clocks or resets.
REQ-005 Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- M_valid_i  in  1  M-stage instruction valid.
- M_icode_i  in  4  Y86 icode.
- M_valE_i  in  64  ALU result / address.
- M_valA_i  in  DATA_W  store data / pop-ret address.
- M_stat_i  in  3  incoming status.
- m_valM_o  out  DATA_W  read data.
- m_stat_o  out  3  resulting status.
- m_valid_o  out  1  result valid.
- m_stall_o  out  1  hold M register and upstream.

Function
REQ-006 Reads SHALL be mrmovq(5), popq(B) and ret(9); writes SHALL be rmmovq(4), pushq(A) and call(8); all other icodes SHALL be no-ops.
REQ-007 The address SHALL be M_valA_i for popq/ret and M_valE_i for all other memory icodes; word index = addr >> log2(DATA_W/8).
REQ-008 FSM states SHALL be IDLE and BUSY; inputs SHALL be sampled only in IDLE with M_valid_i=1.
REQ-009 Writes SHALL commit at the accepting edge; m_valid_o=1 and m_stat_o=M_stat_i in the next cycle; no stall.
REQ-010 No-op icodes SHALL behave as a write with no array access; m_valM_o SHALL be 0.
REQ-011 A read accepted in cycle N with RD_LAT>1 SHALL raise m_stall_o combinationally in cycle N and hold it through cycle N+RD_LAT-2, then enter BUSY with a down-counter loaded to RD_LAT-1.
REQ-012 Read data SHALL be valid with m_valid_o=1 for exactly one cycle, N+RD_LAT; RD_LAT=1 SHALL give no stall and data in N+1.
REQ-013 In BUSY, input changes SHALL be ignored; the FSM SHALL return to IDLE on the edge ending the last BUSY cycle.
REQ-014 Addresses with addr+DATA_W/8 > byte limit SHALL perform no access, no stall, m_stat_o=ADR(3'h3), m_valM_o=0.
REQ-015 If M_stat_i != AOK(3'h1), the instruction SHALL perform no access and no stall; M_stat_i SHALL pass through unchanged.
REQ-016 A read following a write to the same address in the next accepted cycle SHALL return the new data.
REQ-017 When M_valid_i=0 in IDLE, m_valid_o SHALL be 0 next cycle and the other outputs SHALL hold their values.

Reset
REQ-018 On rst_i=1, the FSM SHALL go to IDLE and the counter to 0; outputs SHALL be m_valM_o=0, m_stat_o=AOK, m_valid_o=0 and m_stall_o=0, regardless of clock.
REQ-019 Reset during BUSY SHALL abort the read with no m_valid_o pulse; array contents SHALL NOT be reset.

Configuration
REQ-020 With MEM_ALIGN_CHECK_EN defined, any memory icode whose addr[log2(DATA_W/8)-1:0] != 0 SHALL yield ADR with no access and no stall; when undefined, the low address bits SHALL be ignored.

Verification
REQ-021 rmmovq with valE=0x100 and valA=0xDEADBEEF, then mrmovq with valE=0x100 (RD_LAT=2) -> stall high 1 cycle; m_valM_o=0xDEADBEEF with m_valid_o=1 two cycles after acceptance; stat AOK.
REQ-022 popq with valA=0x1FF8 and valE=0 (DEPTH_WORDS=1024) -> read from 0x1FF8 succeeds; repeat with valA=0x2000 -> m_stat_o=3, m_valM_o=0, no stall.
REQ-023 mrmovq with M_stat_i=INS(3'h4) -> no stall, m_stat_o=4, array unchanged.
REQ-024 Assert rst_i mid-read at RD_LAT=4 -> m_stall_o and m_valid_o drop immediately; a previously written word is still readable after reset.
REQ-025 With MEM_ALIGN_CHECK_EN defined, mrmovq with valE=0x103 -> ADR; when undefined -> data of word 0x100 returned.
REQ-026 Back-to-back mrmovq at RD_LAT=3 -> each result appears 3 cycles after its acceptance; stall covers 2 cycles per read.
